// File: rtl/modport_avmm_sha3.sv
// Avalon-MM agent s0 wrapping a SHA3-256 core (Keccak-f[1600], rate 1088).
// Software loads pre-padded blocks, starts absorption and reads the digest.
module modport_avmm_sha3 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_write_data,
    output logic [31:0] avs_s0_read_data,
    output logic        avs_s0_wait_request
);

    typedef enum logic {ST_IDLE, ST_RUN} phase_t;

    localparam logic [31:0] ID_VALUE = 32'h5348_4133;
    localparam int RHO [25] = '{ 0,  1, 62, 28, 27, 36, 44,  6, 55, 20,  3, 10, 43,
                                25, 39, 41, 45, 15, 21,  8, 18,  2, 61, 56, 14};

    phase_t         phase_q, phase_d;
    logic [1599:0]  state_q;
    logic [1087:0]  block_q;
    logic [4:0]     round_q;
    logic           done_q;
    logic           rd_ack_q;

    logic           busy, is_ctrl, is_block, is_digest;
    logic [5:0]     blk_word;
    logic           stall, wr_en, rd_en, start_go, init_go;
    logic [31:0]    rd_mux;
    logic [1599:0]  round_out;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
    endfunction

    function automatic logic [63:0] rc_of(input logic [4:0] r);
        case (r)
            5'd0:  return 64'h0000_0000_0000_0001;
            5'd1:  return 64'h0000_0000_0000_8082;
            5'd2:  return 64'h8000_0000_0000_808A;
            5'd3:  return 64'h8000_0000_8000_8000;
            5'd4:  return 64'h0000_0000_0000_808B;
            5'd5:  return 64'h0000_0000_8000_0001;
            5'd6:  return 64'h8000_0000_8000_8081;
            5'd7:  return 64'h8000_0000_0000_8009;
            5'd8:  return 64'h0000_0000_0000_008A;
            5'd9:  return 64'h0000_0000_0000_0088;
            5'd10: return 64'h0000_0000_8000_8009;
            5'd11: return 64'h0000_0000_8000_000A;
            5'd12: return 64'h0000_0000_8000_808B;
            5'd13: return 64'h8000_0000_0000_008B;
            5'd14: return 64'h8000_0000_0000_8089;
            5'd15: return 64'h8000_0000_0000_8003;
            5'd16: return 64'h8000_0000_0000_8002;
            5'd17: return 64'h8000_0000_0000_0080;
            5'd18: return 64'h0000_0000_0000_800A;
            5'd19: return 64'h8000_0000_8000_000A;
            5'd20: return 64'h8000_0000_8000_8081;
            5'd21: return 64'h8000_0000_0000_8080;
            5'd22: return 64'h0000_0000_8000_0001;
            5'd23: return 64'h8000_0000_8000_8008;
            default: return 64'h0;
        endcase
    endfunction

    // Lane i = x + 5y occupies state bits [64i+63:64i]
    function automatic logic [1599:0] keccak_round(input logic [1599:0] s, input logic [63:0] rc);
        logic [63:0]   a [25];
        logic [63:0]   b [25];
        logic [63:0]   c [5];
        logic [63:0]   d;
        logic [1599:0] o;
        for (int i = 0; i < 25; i++) a[i] = s[64*i +: 64];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) begin
            d = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
            for (int y = 0; y < 5; y++) a[x+5*y] = a[x+5*y] ^ d;
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x+5*y], RHO[x+5*y]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x+5*y] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        a[0] = a[0] ^ rc;
        for (int i = 0; i < 25; i++) o[64*i +: 64] = a[i];
        return o;
    endfunction

    assign round_out = keccak_round(state_q, rc_of(round_q));

    // Writes to CTRL/BLOCK stall while hashing; a read costs one wait state
    always_comb begin
        is_ctrl   = (avs_s0_address == 8'h00);
        is_block  = (avs_s0_address >= 8'h10) && (avs_s0_address <= 8'h31);
        is_digest = (avs_s0_address[7:3] == 5'b01000);
        blk_word  = 6'(avs_s0_address - 8'h10);
        busy      = (phase_q == ST_RUN);
        stall     = avs_s0_write && busy && (is_ctrl || is_block);
        wr_en     = avs_s0_write && !stall;
        rd_en     = avs_s0_read && !avs_s0_write && !rd_ack_q;
        init_go   = wr_en && is_ctrl && avs_s0_write_data[1];
        start_go  = wr_en && is_ctrl && avs_s0_write_data[0];
        avs_s0_wait_request = stall || rd_en;
    end

    always_comb begin
        rd_mux = 32'h0;
        if (avs_s0_address == 8'h01)
            rd_mux = {30'h0, done_q, busy};
        else if (avs_s0_address == 8'h02)
            rd_mux = ID_VALUE;
        else if (is_block)
            rd_mux = block_q[{blk_word, 5'd0} +: 32];
        else if (is_digest)
            rd_mux = state_q[{avs_s0_address[2:0], 5'd0} +: 32];
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_IDLE: if (start_go) phase_d = ST_RUN;
            ST_RUN:  if (round_q == 5'd23) phase_d = ST_IDLE;
            default: phase_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= ST_IDLE;
        else     phase_q <= phase_d;
    end

    // INIT zeroes the state before a START in the same write absorbs the block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= '0;
            block_q          <= '0;
            round_q          <= '0;
            done_q           <= 1'b0;
            rd_ack_q         <= 1'b0;
            avs_s0_read_data <= '0;
        end else begin
            rd_ack_q <= rd_en;
            if (rd_en) avs_s0_read_data <= rd_mux;
            if (wr_en && is_block) block_q[{blk_word, 5'd0} +: 32] <= avs_s0_write_data;
            if (start_go) begin
                state_q <= (init_go ? 1600'h0 : state_q) ^ {512'h0, block_q};
                round_q <= '0;
                done_q  <= 1'b0;
            end else if (init_go) begin
                state_q <= '0;
                done_q  <= 1'b0;
            end else if (busy) begin
                state_q <= round_out;
                round_q <= (round_q == 5'd23) ? 5'd0 : round_q + 5'd1;
                if (round_q == 5'd23) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modport_avmm_sha3.sv
// Directed bench for modport_avmm_sha3: bus timing, known SHA3-256 digests,
// stall behaviour, reset mid-hash and address decode corner cases.
module tb_modport_avmm_sha3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_write_data;
    logic [31:0] avs_s0_read_data;
    logic        avs_s0_wait_request;

    int total = 0;
    int bad   = 0;

    localparam int WAIT_LIMIT = 200;

    logic [31:0] empty_dig [8] = '{32'hF8C6_FFA7, 32'h66D7_1EBF, 32'h5647_C151, 32'h62D6_61A0,
                                   32'h4DFF_80F5, 32'hFA49_3BE4, 32'h4B0A_D882, 32'h4A43_F880};
    logic [31:0] abc_dig [8]   = '{32'hA75D_983A, 32'hB225_E24F, 32'h2D17_5C04, 32'hBD90_D36B,
                                   32'h6E08_5F85, 32'h5B52_9D3E, 32'h45E2_BF46, 32'h3215_4311};

    modport_avmm_sha3 dut (
        .clk                 (clk),
        .rst                 (rst),
        .avs_s0_address      (avs_s0_address),
        .avs_s0_read         (avs_s0_read),
        .avs_s0_write        (avs_s0_write),
        .avs_s0_write_data   (avs_s0_write_data),
        .avs_s0_read_data    (avs_s0_read_data),
        .avs_s0_wait_request (avs_s0_wait_request)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output int waits);
        @(negedge clk);
        avs_s0_address    = a;
        avs_s0_write_data = d;
        avs_s0_write      = 1'b1;
        waits             = 0;
        #1;
        while (avs_s0_wait_request && waits < WAIT_LIMIT) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= WAIT_LIMIT) begin
            total++;
            bad++;
            $display("[TB] FAIL write_timeout addr=0x%02h waits=%0d limit=%0d", a, waits, WAIT_LIMIT);
        end
        @(posedge clk);
        #1;
        avs_s0_write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        waits          = 0;
        #1;
        while (avs_s0_wait_request && waits < WAIT_LIMIT) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= WAIT_LIMIT) begin
            total++;
            bad++;
            $display("[TB] FAIL read_timeout addr=0x%02h waits=%0d limit=%0d", a, waits, WAIT_LIMIT);
        end
        d = avs_s0_read_data;
        @(posedge clk);
        #1;
        avs_s0_read = 1'b0;
    endtask

    task automatic poll_done(input string tag);
        logic [31:0] st;
        int          w;
        int          tries;
        st    = '0;
        tries = 0;
        while (st != 32'h2 && tries < 100) begin
            bus_read(8'h01, st, w);
            tries++;
        end
        check_output(tag, st, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        int          w;

        rst               = 1'b1;
        avs_s0_address    = '0;
        avs_s0_read       = 1'b0;
        avs_s0_write      = 1'b0;
        avs_s0_write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset_read_data", avs_s0_read_data, 32'h0);
        check_output("reset_wait", {31'h0, avs_s0_wait_request}, 32'h0);

        $display("[TB] register reads after reset");
        bus_read(8'h02, r, w);
        check_output("id_value", r, 32'h5348_4133);
        check_output("id_wait_cycles", w, 32'd1);
        bus_read(8'h01, r, w);
        check_output("status_reset", r, 32'h0);
        bus_read(8'h00, r, w);
        check_output("ctrl_reads_zero", r, 32'h0);

        $display("[TB] empty message hash");
        bus_write(8'h00, 32'h2, w);
        bus_write(8'h10, 32'h0000_0006, w);
        check_output("block_write_wait", w, 32'd0);
        bus_write(8'h31, 32'h8000_0000, w);
        bus_write(8'h00, 32'h1, w);
        check_output("start_write_wait", w, 32'd0);
        bus_read(8'h01, r, w);
        check_output("status_busy", r, 32'h1);
        check_output("busy_read_wait", w, 32'd1);
        poll_done("empty_done");
        for (int k = 0; k < 8; k++) begin
            bus_read(8'h40 + 8'(k), r, w);
            check_output($sformatf("empty_digest%0d", k), r, empty_dig[k]);
        end

        $display("[TB] abc hash with INIT and START in one write");
        bus_write(8'h10, 32'h0663_6261, w);
        bus_write(8'h00, 32'h3, w);
        poll_done("abc_done");
        for (int k = 0; k < 8; k++) begin
            bus_read(8'h40 + 8'(k), r, w);
            check_output($sformatf("abc_digest%0d", k), r, abc_dig[k]);
        end
        bus_write(8'h00, 32'h2, w);
        bus_read(8'h01, r, w);
        check_output("init_clears_done", r, 32'h0);

        $display("[TB] block write stalled during hash");
        bus_write(8'h00, 32'h3, w);
        bus_write(8'h15, 32'h1234_5678, w);
        check_output("stall_cycles", w, 32'd24);
        bus_read(8'h01, r, w);
        check_output("stall_status", r, 32'h2);
        for (int k = 0; k < 8; k++) begin
            bus_read(8'h40 + 8'(k), r, w);
            check_output($sformatf("stall_digest%0d", k), r, abc_dig[k]);
        end
        bus_read(8'h15, r, w);
        check_output("stall_write_landed", r, 32'h1234_5678);

        $display("[TB] reset in the middle of a hash");
        bus_write(8'h00, 32'h1, w);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_read(8'h01, r, w);
        check_output("midreset_status", r, 32'h0);
        for (int k = 0; k < 8; k++) begin
            bus_read(8'h40 + 8'(k), r, w);
            check_output($sformatf("midreset_digest%0d", k), r, 32'h0);
        end
        for (int k = 0; k < 34; k++) begin
            bus_read(8'h10 + 8'(k), r, w);
            check_output($sformatf("midreset_block%0d", k), r, 32'h0);
        end

        $display("[TB] unmapped address and read+write collision");
        bus_write(8'hFF, 32'hDEAD_BEEF, w);
        check_output("unmapped_write_wait", w, 32'd0);
        bus_read(8'hFF, r, w);
        check_output("unmapped_read", r, 32'h0);
        bus_read(8'h02, r, w);
        @(negedge clk);
        avs_s0_address    = 8'h10;
        avs_s0_write_data = 32'hCAFE_F00D;
        avs_s0_read       = 1'b1;
        avs_s0_write      = 1'b1;
        #1;
        check_output("rw_no_wait", {31'h0, avs_s0_wait_request}, 32'h0);
        @(posedge clk);
        #1;
        avs_s0_read  = 1'b0;
        avs_s0_write = 1'b0;
        check_output("rw_read_data_held", avs_s0_read_data, 32'h5348_4133);
        bus_read(8'h10, r, w);
        check_output("rw_write_done", r, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
